// File: rtl/adc_sar_ctrl.sv
// adc_sar_ctrl: successive-approximation controller for a capacitive-DAC SAR ADC.
// Samples the input for SAMPLE_CYCLES cycles, then resolves RESOLUTION bits
// MSB first. Each bit takes one SETTLE cycle, where the trial code is driven,
// and one LATCH cycle, where the comparator decision is captured. The final
// code is delivered with a one-cycle result_valid strobe.
//
// Optional build macro ADC_SAR_CONT_EN: continuous mode. DONE goes straight back
// to SAMPLE while start stays high, so no IDLE cycle is inserted.
//
// Ports:
//   clk          conversion clock
//   rst_n        asynchronous active-low reset
//   start        conversion request, level-sampled in IDLE
//   comp_in      comparator decision (1 = Vin >= DAC trial level)
//   sample_o     DAC top plates tracking the input
//   comp_latch_o comparator latch enable; comp_in is valid this cycle
//   dac_data     trial code to the row/column decoder
//   result       last completed conversion code
//   result_valid one-cycle pulse when result updates
//   busy         high from SAMPLE through DONE
module adc_sar_ctrl #(
    parameter int unsigned RESOLUTION    = 12,
    parameter int unsigned SAMPLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  comp_in,
    output logic                  sample_o,
    output logic                  comp_latch_o,
    output logic [RESOLUTION-1:0] dac_data,
    output logic [RESOLUTION-1:0] result,
    output logic                  result_valid,
    output logic                  busy
);

    localparam int unsigned IDX_W = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SETTLE,
        ST_LATCH,
        ST_DONE
    } state_t;

    state_t                state,        state_nxt;
    logic [CNT_W-1:0]      cnt,          cnt_nxt;
    logic [IDX_W-1:0]      bit_idx,      bit_idx_nxt;
    logic [RESOLUTION-1:0] work,         work_nxt;
    logic                  sample_nxt;
    logic                  comp_latch_nxt;
    logic [RESOLUTION-1:0] dac_nxt;
    logic [RESOLUTION-1:0] result_nxt;
    logic                  valid_nxt;
    logic                  busy_nxt;

    // Next-state and next-output logic; outputs are registered from these values
    // so each output reflects the state it belongs to in the same cycle.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bit_idx_nxt    = bit_idx;
        work_nxt       = work;
        sample_nxt     = 1'b0;
        comp_latch_nxt = 1'b0;
        dac_nxt        = '0;
        result_nxt     = result;
        valid_nxt      = 1'b0;
        busy_nxt       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt  = ST_SAMPLE;
                    cnt_nxt    = '0;
                    sample_nxt = 1'b1;
                    busy_nxt   = 1'b1;
                end
            end

            ST_SAMPLE: begin
                busy_nxt = 1'b1;
                if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
                    state_nxt   = ST_SETTLE;
                    bit_idx_nxt = IDX_W'(RESOLUTION - 1);
                    work_nxt    = '0;
                    dac_nxt     = RESOLUTION'(1) << (RESOLUTION - 1);
                end else begin
                    cnt_nxt    = cnt + CNT_W'(1);
                    sample_nxt = 1'b1;
                end
            end

            ST_SETTLE: begin
                state_nxt      = ST_LATCH;
                busy_nxt       = 1'b1;
                comp_latch_nxt = 1'b1;
                dac_nxt        = dac_data;
            end

            ST_LATCH: begin
                busy_nxt          = 1'b1;
                work_nxt[bit_idx] = comp_in;
                if (bit_idx == '0) begin
                    state_nxt  = ST_DONE;
                    result_nxt = work_nxt;
                    valid_nxt  = 1'b1;
                    dac_nxt    = work_nxt;
                end else begin
                    state_nxt   = ST_SETTLE;
                    bit_idx_nxt = bit_idx - IDX_W'(1);
                    dac_nxt     = work_nxt | (RESOLUTION'(1) << bit_idx_nxt);
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
`ifdef ADC_SAR_CONT_EN
                // Back-to-back conversions while start stays high.
                if (start) begin
                    state_nxt  = ST_SAMPLE;
                    cnt_nxt    = '0;
                    sample_nxt = 1'b1;
                    busy_nxt   = 1'b1;
                end
`endif
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bit_idx      <= IDX_W'(RESOLUTION - 1);
            work         <= '0;
            sample_o     <= 1'b0;
            comp_latch_o <= 1'b0;
            dac_data     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            work         <= work_nxt;
            sample_o     <= sample_nxt;
            comp_latch_o <= comp_latch_nxt;
            dac_data     <= dac_nxt;
            result       <= result_nxt;
            result_valid <= valid_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_adc_sar_ctrl.sv
// Self-checking bench for adc_sar_ctrl with an ideal comparator model.
module tb_adc_sar_ctrl;

    localparam int RES = 12;
    localparam int SC  = 2;
    localparam int LAT = 1 + SC + 2 * RES;
`ifdef ADC_SAR_CONT_EN
    localparam int PER = LAT;
`else
    localparam int PER = LAT + 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           comp_in;
    logic           sample_o;
    logic           comp_latch_o;
    logic [RES-1:0] dac_data;
    logic [RES-1:0] result;
    logic           result_valid;
    logic           busy;

    int vin = 0;
    bit noise = 1'b0;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int trace_q[$];
    int latches;

    adc_sar_ctrl #(.RESOLUTION(RES), .SAMPLE_CYCLES(SC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .comp_in      (comp_in),
        .sample_o     (sample_o),
        .comp_latch_o (comp_latch_o),
        .dac_data     (dac_data),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) noise <= 1'($urandom_range(0, 1));

    // Ideal comparator; random garbage whenever the latch is not enabled.
    assign comp_in = comp_latch_o ? (vin >= int'(dac_data)) : noise;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Binary search over the interval [lo, lo + 2^i): returns the trial sequence.
    function automatic void model_trials(input int v, output int tr[RES]);
        int lo = 0;
        for (int i = RES - 1; i >= 0; i--) begin
            tr[RES - 1 - i] = lo + (2 ** i);
            if (v >= lo + (2 ** i)) lo = lo + (2 ** i);
        end
    endfunction

    function automatic int model_result(input int v);
        return (v > (2 ** RES) - 1) ? (2 ** RES) - 1 : v;
    endfunction

    // One conversion from IDLE; start pulses at cycles pa/pb of the conversion.
    task automatic convert(input int v, input int pa, input int pb,
                           output int res, output int lat, output int nvalid,
                           output int busy_gaps);
        int t0;
        int rel;
        @(negedge clk);
        vin = v;
        start = 1'b1;
        t0 = cyc;
        nvalid = 0;
        lat = -1;
        res = -1;
        busy_gaps = 0;
        latches = 0;
        trace_q.delete();
        for (int k = 1; k <= PER + 12; k++) begin
            @(negedge clk);
            rel = cyc - t0;
            start = (rel == pa || rel == pb) ? 1'b1 : 1'b0;
            if (rel <= LAT && !busy) busy_gaps++;
            if (comp_latch_o) latches++;
            if (busy && !sample_o && !comp_latch_o && !result_valid)
                trace_q.push_back(int'(dac_data));
            if (result_valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat = rel;
                    res = int'(result);
                end
            end
        end
    endtask

    task automatic check_conv(input string tag, input int v);
        int res, lat, nv, gaps;
        convert(v, -1, -1, res, lat, nv, gaps);
        check({tag, "_result"}, res, model_result(v));
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_nvalid"}, nv, 1);
        check({tag, "_hold"}, int'(result), model_result(v));
        check({tag, "_idle_busy"}, int'(busy), 0);
    endtask

    initial begin
        int res, lat, nv, gaps;
        int tr[RES];
        int exp_trace[RES];
        int vals[$];
        int vcyc[$];
        int t0;
        int v;
        bit seen;

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sample", int'(sample_o), 0);
        check("rst_latch", int'(comp_latch_o), 0);
        check("rst_dac", int'(dac_data), 0);
        check("rst_result", int'(result), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check_conv("vin0", 0);
        check_conv("vin4095", 4095);
        check_conv("vin2048", 2048);

        // Trial-code trace for 1365 against a fixed table and the search model.
        exp_trace = '{2048, 1024, 1536, 1280, 1408, 1344, 1376, 1360, 1368, 1364, 1366, 1365};
        model_trials(1365, tr);
        convert(1365, -1, -1, res, lat, nv, gaps);
        check("t1365_result", res, 1365);
        check("t1365_latency", lat, LAT);
        check("t1365_latches", latches, RES);
        check("t1365_trace_len", trace_q.size(), RES);
        for (int i = 0; i < RES; i++) begin
            check($sformatf("t1365_trace%0d", i), (i < trace_q.size()) ? trace_q[i] : -1, exp_trace[i]);
            check($sformatf("t1365_model%0d", i), tr[i], exp_trace[i]);
        end

        // start pulses during a conversion are ignored.
        convert(777, 5, 20, res, lat, nv, gaps);
        check("ign_result", res, 777);
        check("ign_latency", lat, LAT);
        check("ign_nvalid", nv, 1);
        check("ign_busy_gaps", gaps, 0);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        vin = 3000;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc - t0 < 10) @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("arst_sample", int'(sample_o), 0);
        check("arst_latch", int'(comp_latch_o), 0);
        check("arst_dac", int'(dac_data), 0);
        check("arst_result", int'(result), 0);
        check("arst_valid", int'(result_valid), 0);
        check("arst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy || result_valid) seen = 1'b1;
        end
        check("post_rst_idle", int'(seen), 0);
        check_conv("vin3000", 3000);

        // Random codes against the model.
        repeat (6) begin
            v = int'($urandom_range(0, 4095));
            check_conv($sformatf("rnd%0d", v), v);
        end

        // start held high with the input toggling between two levels.
        @(negedge clk);
        vin = 100;
        start = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 4 * PER + 10 && vals.size() < 3; k++) begin
            @(negedge clk);
            if (result_valid) begin
                vals.push_back(int'(result));
                vcyc.push_back(cyc - t0);
                vin = (vin == 100) ? 3900 : 100;
            end
        end
        check("cont_count", vals.size(), 3);
        if (vals.size() == 3) begin
            check("cont_res0", vals[0], 100);
            check("cont_res1", vals[1], 3900);
            check("cont_res2", vals[2], 100);
            check("cont_lat0", vcyc[0], LAT);
            check("cont_per1", vcyc[1] - vcyc[0], PER);
            check("cont_per2", vcyc[2] - vcyc[1], PER);
        end

        // Dropping start mid-conversion lets that conversion finish, then idle.
        repeat (10) @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        res = -1;
        for (int k = 0; k < PER + 5 && !seen; k++) begin
            @(negedge clk);
            if (result_valid) begin
                seen = 1'b1;
                res = int'(result);
            end
        end
        check("stop_seen", int'(seen), 1);
        check("stop_result", res, 3900);
        @(negedge clk);
        check("stop_busy", int'(busy), 0);
        nv = 0;
        repeat (PER + 5) begin
            @(negedge clk);
            if (busy || result_valid) nv++;
        end
        check("stop_stays_idle", nv, 0);
        check("stop_hold", int'(result), 3900);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
